// File: rtl/cpu_sequencer.sv
// ============================================================================
// cpu_sequencer
// ----------------------------------------------------------------------------
// Multi-cycle control unit for the 4-bit accumulator processor. Each
// instruction runs in three states, FETCH -> EXEC -> WB. All datapath
// strobes for an instruction are asserted together, for one cycle, in WB.
//
// Build option:
//   SEQ_ILLEGAL_TRAP_EN  When defined, opcodes 0x9-0xE trap. The sequencer
//                        goes EXEC -> HALT with no write-back and sets the
//                        sticky `illegal` flag. When undefined, those opcodes
//                        execute as NOP and `illegal` is tied to 0.
//
// Ports:
//   clk      in   system clock, rising-edge active
//   rst      in   asynchronous, active-low reset
//   run      in   level, 1 = execute continuously
//   step     in   pulse, runs one instruction when idle and run=0
//   opcode   in   [3:0] upper ROM nibble at the current PC
//   zero     in   register output equals 4'h0 (sampled in WB by JZ)
//   pc_inc   out  PC increments at this edge
//   pc_load  out  PC loads the immediate nibble at this edge
//   acc_ce   out  accumulator write enable
//   reg_ce   out  register write enable (captures ALU result)
//   mux_sel  out  1 = immediate into accumulator, 0 = accumulator feedback
//   alu_op   out  [1:0] 00 add, 01 sub, 10 and, 11 or
//   busy     out  1 in FETCH, EXEC or WB
//   halted   out  1 in HALT
//   illegal  out  halted by an undefined opcode (trap build only)
// ============================================================================
module cpu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       step,
    input  logic [3:0] opcode,
    input  logic       zero,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       acc_ce,
    output logic       reg_ce,
    output logic       mux_sel,
    output logic [1:0] alu_op,
    output logic       busy,
    output logic       halted,
    output logic       illegal
);

    // ------------------------------------------------------------------
    // Opcode map
    // ------------------------------------------------------------------
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_MOV = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] ir;           // instruction register, loaded in FETCH
    logic       single_step;  // current instruction was started by step

    logic       is_alu_op;
    logic       ir_undef;

    // ALU instructions occupy 0x2..0x5; alu_op is the offset from ADD.
    assign is_alu_op = (ir >= OP_ADD) && (ir <= OP_OR);

`ifdef SEQ_ILLEGAL_TRAP_EN
    localparam logic [3:0] OP_UNDEF_LO = 4'h9;
    localparam logic [3:0] OP_UNDEF_HI = 4'hE;
    assign ir_undef = (ir >= OP_UNDEF_LO) && (ir <= OP_UNDEF_HI);
`else
    // Undefined opcodes fall through to the NOP path, so no trap is needed.
    assign ir_undef = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State, instruction register and step-mode latch
    // ------------------------------------------------------------------
    // NOTE: every register here updates with non-blocking (<=) assignments,
    // so all flops sample the pre-edge values of the others regardless of
    // statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            // NOTE: ir is reset even though FETCH always overwrites it. This
            // keeps the decode outputs defined straight out of reset.
            ir          <= 4'h0;
            single_step <= 1'b0;
        end else begin
            state <= next_state;

            if (state == S_FETCH) begin
                ir <= opcode;
            end

            // Mode is decided only when an instruction starts from IDLE.
            // run has priority over step.
            if (state == S_IDLE) begin
                if (run) begin
                    single_step <= 1'b0;
                end else if (step) begin
                    single_step <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: next_state gets its default before the case. Without that,
    // any path that leaves it unassigned infers a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: begin
                if (run || step) begin
                    next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                next_state = S_EXEC;
            end
            S_EXEC: begin
                // A trapped opcode skips WB, so none of its strobes can fire.
                if (ir_undef) begin
                    next_state = S_HALT;
                end else begin
                    next_state = S_WB;
                end
            end
            S_WB: begin
                if (ir == OP_HLT) begin
                    next_state = S_HALT;
                end else if (run && !single_step) begin
                    // Back-to-back FETCH, with no idle cycle between instructions.
                    next_state = S_FETCH;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_HALT: begin
                // Only reset leaves HALT. run and step are ignored here.
                next_state = S_HALT;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. All outputs come from state and ir, so reset forces
    // them to 0 at once, without waiting for a clock edge.
    // ------------------------------------------------------------------
    always_comb begin
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        acc_ce  = 1'b0;
        reg_ce  = 1'b0;
        mux_sel = 1'b0;
        alu_op  = 2'b00;

        // ALU and mux selects are driven from EXEC so the datapath settles
        // before the WB edge. They hold their values through WB.
        if ((state == S_EXEC) || (state == S_WB)) begin
            mux_sel = (ir == OP_LDI);
            if (is_alu_op) begin
                alu_op = 2'(ir - OP_ADD);
            end
        end

        if (state == S_WB) begin
            unique case (ir)
                OP_NOP: pc_inc = 1'b1;
                OP_LDI: begin
                    acc_ce = 1'b1;
                    pc_inc = 1'b1;
                end
                OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                    reg_ce = 1'b1;
                    pc_inc = 1'b1;
                end
                OP_MOV: begin
                    acc_ce = 1'b1;
                    pc_inc = 1'b1;
                end
                OP_JMP: pc_load = 1'b1;
                OP_JZ: begin
                    // zero is sampled here, in WB, so the branch sees the
                    // register value produced by the previous instruction.
                    pc_load = zero;
                    pc_inc  = !zero;
                end
                OP_HLT: begin
                    // No strobes. Next state is HALT.
                end
                default: begin
                    // 0x9-0xE reach WB only in the non-trap build, where
                    // they execute as NOP.
                    pc_inc = 1'b1;
                end
            endcase
        end
    end

    assign busy   = (state == S_FETCH) || (state == S_EXEC) || (state == S_WB);
    assign halted = (state == S_HALT);

    // ------------------------------------------------------------------
    // Sticky illegal-opcode flag
    // ------------------------------------------------------------------
`ifdef SEQ_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_q <= 1'b0;
        end else if ((state == S_EXEC) && ir_undef) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control unit for the 4-bit accumulator processor. Replaces the purely combinational instruction decoding with a fetch/execute/write-back state machine. The sequencer drives the program counter, accumulator, register, ALU and immediate mux strobes, and adds run, single-step, conditional jump and halt control. It sits between the 16x8 program ROM (opcode nibble) and the datapath enables.

## Interface
Parameters:
- none; the opcode map and the 4-bit width are fixed.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = execute instructions continuously.
- step  in  1  single-cycle pulse; executes exactly one instruction when idle and run=0.
- opcode  in  4  upper ROM nibble at the current PC.
- zero  in  1  1 when the register output equals 4'h0.
- pc_inc  out  1  PC advances by 1 at this edge.
- pc_load  out  1  PC loads the immediate nibble at this edge.
- acc_ce  out  1  accumulator write enable.
- reg_ce  out  1  register write enable (writes ALU result).
- mux_sel  out  1  1 = immediate into accumulator, 0 = accumulator feedback.
- alu_op  out  2  ALU operation: 00 add, 01 sub, 10 and, 11 or.
- busy  out  1  1 in FETCH, EXEC or WB.
- halted  out  1  1 in HALT.
- illegal  out  1  1 when halted by an undefined opcode (trap build only).

## Operation
- States: IDLE, FETCH, EXEC, WB, HALT.
- IDLE -> FETCH when run=1, or when step=1 with run=0. The step request is latched as single-step mode.
- FETCH: the internal instruction register captures `opcode`. No strobes are asserted.
- EXEC: `alu_op` and `mux_sel` are driven from the instruction register so the datapath settles. No write strobes are asserted.
- WB: exactly one instruction's write strobes and PC update are asserted for one cycle.
- After WB: go to FETCH if run=1 and not single-step mode. Otherwise go to IDLE.
- Opcode map (action taken in WB):
  - 0x0 NOP: pc_inc.
  - 0x1 LDI: mux_sel=1, acc_ce, pc_inc.
  - 0x2 ADD, 0x3 SUB, 0x4 AND, 0x5 OR: alu_op = opcode-2, reg_ce, pc_inc.
  - 0x6 MOV: mux_sel=0, acc_ce, pc_inc.
  - 0x7 JMP: pc_load.
  - 0x8 JZ: pc_load if zero=1, otherwise pc_inc. `zero` is sampled in WB.
  - 0xF HLT: no strobes; next state is HALT.
  - 0x9-0xE: undefined; handling is set under Configuration.
- HALT is left only by reset. `run` and `step` are ignored while halted.
- `alu_op` and `mux_sel` hold their EXEC values through WB. They are 0 in IDLE, FETCH and HALT.
- pc_inc and pc_load are never asserted together.

## Timing
- Reset (rst=0, asynchronous): state IDLE; instruction register = 0.
  - All outputs 0 immediately, without waiting for a clock edge.
- Reset released mid-instruction: the instruction is abandoned with no partial write. Execution restarts from IDLE.
- Every instruction takes 3 cycles (FETCH, EXEC, WB). HLT takes 3 cycles to enter HALT.
- Continuous run throughput: one instruction per 3 cycles. No idle cycle between WB and the next FETCH.
- From run rising (sampled in IDLE) to the first WB strobe: 3 edges.
- `step` is sampled only in IDLE.
  - A pulse arriving during busy is ignored.
  - If run and step are both 1, run wins (continuous mode).
- If run falls during an instruction, that instruction completes. The sequencer then enters IDLE.
- PC wrap (0xF -> 0x0) is the counter's concern. The sequencer just asserts pc_inc.

## Configuration
- Macro: `SEQ_ILLEGAL_TRAP_EN`.
- Defined: opcodes 0x9-0xE go FETCH -> EXEC -> HALT with no WB strobes, and `illegal` is set to 1. `illegal` is cleared only by reset.
- Undefined: opcodes 0x9-0xE execute as NOP (pc_inc in WB), and `illegal` is tied to 0.

## Test plan
- Reset and idle: hold rst=0 mid-EXEC of an LDI. Required: all outputs 0 at once, and no acc_ce pulse after release while run=0.
- LDI then ADD, run=1: with opcode 0x1 then 0x2, acc_ce fires on the 3rd edge and reg_ce with alu_op=00 on the 6th edge. Each is asserted for exactly 1 cycle, with pc_inc in the same cycle.
- Single step: with run=0, a step pulse gives exactly one WB (pc_inc=1) and a return to IDLE. A second pulse during busy adds no extra instruction.
- JZ: opcode 0x8 with zero=1 gives pc_load=1 and pc_inc=0 in WB. With zero=0 it gives pc_inc=1 and pc_load=0.
- HLT: opcode 0xF gives halted=1 after 3 cycles and no strobes after that. Toggling run/step has no effect, and rst=0 clears halted.
- Undefined opcode 0xA: with `SEQ_ILLEGAL_TRAP_EN`, halted=1 and illegal=1 with no pc_inc. Without the macro, pc_inc in WB and illegal stays 0.
